universal_shift_reg: RTL and testbench

- Parametrised universal shift register. Successor to the fixed 4-bit serial/parallel register.
- Adds left and right shifting, rotation, arithmetic shift, explicit clear, an enable, and serial outputs on both ends.
- Adds a shift counter with a frame-complete pulse, so the block can act as a WIDTH-bit serial-to-parallel deserialiser.
- Sits between the board switches and the LED/7-segment outputs in the top-level lab design.

---
 rtl/universal_shift_reg_if.sv | 28 ++
 rtl/universal_shift_reg.sv | 96 +++++++++
 tb/tb_universal_shift_reg.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/universal_shift_reg_if.sv
// Universal shift register bus: control/data in, register state out.
// The master drives operations, the slave (the register) reports state.
interface universal_shift_reg_if #(
    parameter int WIDTH = 8
);
    localparam int CW = $clog2(WIDTH);

    logic             en;
    logic [2:0]       mode;
    logic             ser_in_r;
    logic             ser_in_l;
    logic [WIDTH-1:0] par_in;
    logic [WIDTH-1:0] q;
    logic             ser_out_r;
    logic             ser_out_l;
    logic [CW-1:0]    bit_cnt;
    logic             frame_done;

    modport master (
        output en, mode, ser_in_r, ser_in_l, par_in,
        input  q, ser_out_r, ser_out_l, bit_cnt, frame_done
    );

    modport slave (
        input  en, mode, ser_in_r, ser_in_l, par_in,
        output q, ser_out_r, ser_out_l, bit_cnt, frame_done
    );
endinterface

// File: rtl/universal_shift_reg.sv
// Parametrised universal shift register with shift counter and
// frame-complete pulse, usable as a WIDTH-bit deserialiser.
module universal_shift_reg #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic                 clk_2,
    input  logic                 reset,
    universal_shift_reg_if.slave bus
);
    localparam logic [2:0] M_HOLD  = 3'b000;
    localparam logic [2:0] M_SHR   = 3'b001;
    localparam logic [2:0] M_SHL   = 3'b010;
    localparam logic [2:0] M_ROR   = 3'b011;
    localparam logic [2:0] M_ROL   = 3'b100;
    localparam logic [2:0] M_LOAD  = 3'b101;
    localparam logic [2:0] M_CLEAR = 3'b110;
    localparam logic [2:0] M_ASR   = 3'b111;

    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_nxt;
    logic [CW-1:0]    cnt_r;
    logic             done_r;
    logic             is_shift;
    logic             cnt_zero;

    // Next register value and counter action for the selected mode
    always_comb begin
        q_nxt    = q_r;
        is_shift = 1'b0;
        cnt_zero = 1'b0;
        unique case (bus.mode)
            M_HOLD:  q_nxt = q_r;
            M_SHR: begin
                q_nxt    = {bus.ser_in_r, q_r[WIDTH-1:1]};
                is_shift = 1'b1;
            end
            M_SHL: begin
                q_nxt    = {q_r[WIDTH-2:0], bus.ser_in_l};
                is_shift = 1'b1;
            end
            M_ROR: begin
                q_nxt    = {q_r[0], q_r[WIDTH-1:1]};
                is_shift = 1'b1;
            end
            M_ROL: begin
                q_nxt    = {q_r[WIDTH-2:0], q_r[WIDTH-1]};
                is_shift = 1'b1;
            end
            M_LOAD: begin
                q_nxt    = bus.par_in;
                cnt_zero = 1'b1;
            end
            M_CLEAR: begin
                q_nxt    = '0;
                cnt_zero = 1'b1;
            end
            M_ASR: begin
                q_nxt    = {q_r[WIDTH-1], q_r[WIDTH-1:1]};
                is_shift = 1'b1;
            end
        endcase
    end

    // Register, shift counter and one-cycle frame pulse
    always_ff @(posedge clk_2) begin
        if (reset) begin
            q_r    <= '0;
            cnt_r  <= '0;
            done_r <= 1'b0;
        end else if (!bus.en) begin
            done_r <= 1'b0;
        end else begin
            q_r    <= q_nxt;
            done_r <= 1'b0;
            if (cnt_zero) begin
                cnt_r <= '0;
            end else if (is_shift) begin
                if (cnt_r == CNT_LAST) begin
                    cnt_r  <= '0;
                    done_r <= 1'b1;
                end else begin
                    cnt_r <= cnt_r + 1'b1;
                end
            end
        end
    end

    assign bus.q          = q_r;
    assign bus.ser_out_r  = q_r[0];
    assign bus.ser_out_l  = q_r[WIDTH-1];
    assign bus.bit_cnt    = cnt_r;
    assign bus.frame_done = done_r;
endmodule

// File: tb/tb_universal_shift_reg.sv
// Bench for universal_shift_reg: 8-bit and 4-bit instances driven
// in lockstep and compared every cycle against an arithmetic model.
module tb_universal_shift_reg;
    logic       clk_2 = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic [2:0] mode = 3'b000;
    logic       sr = 1'b0;
    logic       sl = 1'b0;
    logic [7:0] par = 8'h00;
    bit         chk_on = 1'b0;
    int         nvec = 0;
    int         nerr = 0;

    logic [7:0] mq[2];
    int         msc[2];
    bit         mdone[2];

    universal_shift_reg_if #(.WIDTH(8)) b8 ();
    universal_shift_reg_if #(.WIDTH(4)) b4 ();

    assign b8.en = en;
    assign b8.mode = mode;
    assign b8.ser_in_r = sr;
    assign b8.ser_in_l = sl;
    assign b8.par_in = par;
    assign b4.en = en;
    assign b4.mode = mode;
    assign b4.ser_in_r = sr;
    assign b4.ser_in_l = sl;
    assign b4.par_in = par[3:0];

    universal_shift_reg #(.WIDTH(8)) dut8 (
        .clk_2(clk_2),
        .reset(rst),
        .bus(b8.slave)
    );

    universal_shift_reg #(.WIDTH(4)) dut4 (
        .clk_2(clk_2),
        .reset(rst),
        .bus(b4.slave)
    );

    // Free-running clock
    always #5 clk_2 = ~clk_2;

    function automatic int next_q(int w, int q, logic [2:0] m,
                                  int s_r, int s_l, int p);
        int mask;
        int top;
        mask = (1 << w) - 1;
        top  = 1 << (w - 1);
        case (m)
            3'd1: return (q / 2) + s_r * top;
            3'd2: return ((q * 2) + s_l) & mask;
            3'd3: return (q / 2) + (q % 2) * top;
            3'd4: return ((q * 2) + ((q >= top) ? 1 : 0)) & mask;
            3'd5: return p & mask;
            3'd6: return 0;
            3'd7: return (q / 2) + ((q >= top) ? top : 0);
            default: return q;
        endcase
    endfunction

    // Reference model: shift count kept unbounded, reduced mod width
    always @(posedge clk_2) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                mq[i]    <= 8'h00;
                msc[i]   <= 0;
                mdone[i] <= 1'b0;
            end else if (!en) begin
                mdone[i] <= 1'b0;
            end else begin
                mq[i] <= 8'(next_q(i == 0 ? 8 : 4, int'(mq[i]), mode,
                                   int'(sr), int'(sl), int'(par)));
                mdone[i] <= 1'b0;
                if (mode == 3'd5 || mode == 3'd6) begin
                    msc[i] <= 0;
                end else if (mode != 3'd0) begin
                    msc[i]   <= msc[i] + 1;
                    mdone[i] <= ((msc[i] + 1) % (i == 0 ? 8 : 4)) == 0;
                end
            end
        end
    end

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of both instances against the model
    always @(negedge clk_2) begin
        if (chk_on) begin
            check("q8", b8.q, mq[0]);
            check("cnt8", b8.bit_cnt, msc[0] % 8);
            check("done8", b8.frame_done, mdone[0]);
            check("sor8", b8.ser_out_r, mq[0][0]);
            check("sol8", b8.ser_out_l, mq[0][7]);
            check("q4", b4.q, mq[1]);
            check("cnt4", b4.bit_cnt, msc[1] % 4);
            check("done4", b4.frame_done, mdone[1]);
            check("sor4", b4.ser_out_r, mq[1][0]);
            check("sol4", b4.ser_out_l, mq[1][3]);
        end
    end

    task automatic step(logic r, logic e, logic [2:0] m,
                        logic s_r, logic s_l, logic [7:0] p);
        rst  = r;
        en   = e;
        mode = m;
        sr   = s_r;
        sl   = s_l;
        par  = p;
        @(negedge clk_2);
        #1;
    endtask

    initial begin
        logic [7:0] bits;
        int p8;
        int p4;
        step(1, 0, 3'd0, 0, 0, 8'h00);
        chk_on = 1'b1;
        step(1, 0, 3'd5, 0, 0, 8'h5A);
        step(0, 1, 3'd5, 0, 0, 8'h77);
        step(1, 1, 3'd5, 0, 0, 8'hFF);
        check("rst_q", b8.q, 8'h00);
        check("rst_cnt", b8.bit_cnt, 0);
        check("rst_done", b8.frame_done, 0);

        step(0, 1, 3'd5, 0, 0, 8'hA5);
        check("load_q", b8.q, 8'hA5);
        repeat (3) step(0, 0, 3'd1, 1, 1, 8'h00);
        check("hold_q", b8.q, 8'hA5);
        check("hold_cnt", b8.bit_cnt, 0);

        step(0, 1, 3'd6, 0, 0, 8'h00);
        bits = 8'b0100_1101;
        for (int k = 0; k < 8; k++) begin
            step(0, 1, 3'd1, bits[k], 0, 8'h00);
            check("des_cnt", b8.bit_cnt, (k + 1) % 8);
        end
        check("des_q", b8.q, 8'h4D);
        check("des_done", b8.frame_done, 1);
        step(0, 1, 3'd0, 0, 0, 8'h00);
        check("des_done_end", b8.frame_done, 0);

        step(0, 1, 3'd5, 0, 0, 8'h81);
        step(0, 1, 3'd4, 0, 0, 8'h00);
        check("rol", b8.q, 8'h03);
        step(0, 1, 3'd3, 0, 0, 8'h00);
        step(0, 1, 3'd3, 0, 0, 8'h00);
        check("ror2", b8.q, 8'hC0);
        step(0, 1, 3'd5, 0, 0, 8'h90);
        step(0, 1, 3'd7, 0, 0, 8'h00);
        check("asr", b8.q, 8'hC8);
        step(0, 1, 3'd5, 0, 0, 8'h80);
        step(0, 1, 3'd2, 0, 1, 8'h00);
        check("shl", b8.q, 8'h01);

        repeat (5) step(0, 1, 3'd1, 1, 0, 8'h00);
        step(0, 1, 3'd5, 0, 0, 8'h3C);
        check("abort_cnt", b8.bit_cnt, 0);
        check("abort_done", b8.frame_done, 0);
        p8 = 0;
        p4 = 0;
        for (int k = 0; k < 8; k++) begin
            step(0, 1, 3'd2, 0, k[0], 8'h00);
            if (b8.frame_done === 1'b1) p8++;
            if (b4.frame_done === 1'b1) p4++;
        end
        check("pulses8", p8, 1);
        check("pulses4", p4, 2);

        step(0, 1, 3'd5, 0, 0, 8'h6B);
        repeat (7) step(0, 1, 3'd1, 1, 0, 8'h00);
        check("coll_cnt", b8.bit_cnt, 7);
        check("coll_cnt4", b4.bit_cnt, 3);
        step(1, 1, 3'd1, 1, 0, 8'h00);
        check("coll_q", b8.q, 8'h00);
        check("coll_cnt0", b8.bit_cnt, 0);
        check("coll_done", b8.frame_done, 0);
        check("coll_done4", b4.frame_done, 0);
        repeat (3) step(0, 1, 3'd0, 0, 0, 8'h00);
        check("coll_after", b8.frame_done, 0);

        for (int k = 0; k < 600; k++) begin
            step($urandom_range(31) == 0, $urandom_range(7) != 0,
                 3'($urandom_range(7)), 1'($urandom_range(1)),
                 1'($urandom_range(1)), 8'($urandom_range(255)));
        end
        chk_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    // Hard stop in case the run ever stalls
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end
endmodule
